// File: rtl/perf_stat_monitor.sv
// Run statistics for the single-cycle core plus a debounced, button-selected display source.
// Counters saturate and freeze once the halt syscall is seen; display path keeps running.
module perf_stat_monitor #(
  parameter int unsigned DATA_BITS       = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_BITS        = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pcen,
  input  logic                 syscall,
  input  logic                 v0_is_34,
  input  logic                 jmp,
  input  logic                 jr,
  input  logic                 branch_taken,
  input  logic [DATA_BITS-1:0] led_in,
  input  logic                 btn_raw,
  output logic [DATA_BITS-1:0] disp_data,
  output logic [2:0]           disp_sel,
  output logic                 halted
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  localparam logic [DATA_BITS-1:0] CntMax = '1;
  localparam logic [DATA_BITS-1:0] CntOne = DATA_BITS'(1);
  localparam logic [CNT_BITS-1:0]  DebMax = CNT_BITS'(DEBOUNCE_CYCLES);
  localparam logic [CNT_BITS-1:0]  DebOne = CNT_BITS'(1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] instr_cnt_q, instr_cnt_d;
  logic [DATA_BITS-1:0] jump_cnt_q, jump_cnt_d;
  logic [DATA_BITS-1:0] branch_cnt_q, branch_cnt_d;
  logic [DATA_BITS-1:0] print_cnt_q, print_cnt_d;
  logic                 sync1_q, sync2_q;
  logic [CNT_BITS-1:0]  deb_q, deb_d;
  logic                 press;
  logic [2:0]           disp_sel_q, disp_sel_d;
  logic [DATA_BITS-1:0] disp_data_q, disp_mux;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StRun;
    else      state_q <= state_d;
  end

  // FSM next state: halt syscall is terminal until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (syscall && !v0_is_34) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // FSM outputs
  always_comb begin
    halted = (state_q == StHalt);
  end

  always_comb begin
    instr_cnt_d  = instr_cnt_q;
    jump_cnt_d   = jump_cnt_q;
    branch_cnt_d = branch_cnt_q;
    print_cnt_d  = print_cnt_q;
    if (state_q == StRun) begin
      if (pcen && instr_cnt_q != CntMax) instr_cnt_d = instr_cnt_q + CntOne;
      if (pcen && (jmp || jr) && jump_cnt_q != CntMax) jump_cnt_d = jump_cnt_q + CntOne;
      // A jump overrides pcsel, so only pure conditional branches count here
      if (pcen && branch_taken && !jmp && !jr && branch_cnt_q != CntMax) begin
        branch_cnt_d = branch_cnt_q + CntOne;
      end
      if (syscall && v0_is_34 && print_cnt_q != CntMax) print_cnt_d = print_cnt_q + CntOne;
    end
  end

  // Pulse only on the step into saturation, so a held button advances once
  assign press = sync2_q && (deb_q == DebMax - DebOne);

  always_comb begin
    deb_d = deb_q;
    if (!sync2_q)           deb_d = '0;
    else if (deb_q != DebMax) deb_d = deb_q + DebOne;
  end

  always_comb begin
    disp_sel_d = disp_sel_q;
    if (press) disp_sel_d = (disp_sel_q >= 3'd4) ? 3'd0 : disp_sel_q + 3'd1;
  end

  always_comb begin
    case (disp_sel_q)
      3'd0:    disp_mux = led_in;
      3'd1:    disp_mux = instr_cnt_q;
      3'd2:    disp_mux = jump_cnt_q;
      3'd3:    disp_mux = branch_cnt_q;
      3'd4:    disp_mux = print_cnt_q;
      default: disp_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_q  <= '0;
      jump_cnt_q   <= '0;
      branch_cnt_q <= '0;
      print_cnt_q  <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_q        <= '0;
      disp_sel_q   <= 3'd0;
      disp_data_q  <= '0;
    end else begin
      instr_cnt_q  <= instr_cnt_d;
      jump_cnt_q   <= jump_cnt_d;
      branch_cnt_q <= branch_cnt_d;
      print_cnt_q  <= print_cnt_d;
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      disp_sel_q   <= disp_sel_d;
      disp_data_q  <= disp_mux;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_sel  = disp_sel_q;

endmodule

// File: tb/tb_perf_stat_monitor.sv
// Directed bench for perf_stat_monitor; expected display values queued as stimulus is applied.
module tb_perf_stat_monitor;

  localparam int unsigned D = 16;

  logic        clk, rst, pcen, syscall, v0_is_34, jmp, jr, branch_taken, btn_raw;
  logic [31:0] led_in, disp_data;
  logic [2:0]  disp_sel;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  perf_stat_monitor #(
    .DATA_BITS      (32),
    .DEBOUNCE_CYCLES(D),
    .CNT_BITS       (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pcen        (pcen),
    .syscall     (syscall),
    .v0_is_34    (v0_is_34),
    .jmp         (jmp),
    .jr          (jr),
    .branch_taken(branch_taken),
    .led_in      (led_in),
    .btn_raw     (btn_raw),
    .disp_data   (disp_data),
    .disp_sel    (disp_sel),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, disp_data, e.val);
    end
  endtask

  // Clean press: sel advances at edge 2+D, disp_data one edge later, then drain the synchroniser
  task automatic press();
    btn_raw = 1'b1;
    tick(D + 2);
    btn_raw = 1'b0;
    tick(3);
  endtask

  task automatic idle_inputs();
    pcen = 0; syscall = 0; v0_is_34 = 0; jmp = 0; jr = 0; branch_taken = 0; btn_raw = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    led_in = 32'h1234_5678;
    // Inputs thrash while reset is held
    for (int i = 0; i < 8; i++) begin
      {pcen, syscall, v0_is_34, jmp, jr, branch_taken, btn_raw} = 7'($urandom);
      led_in = $urandom;
      tick();
    end
    chk("rst_disp_data", disp_data, 32'h0);
    chk("rst_disp_sel", {29'h0, disp_sel}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    idle_inputs();
    led_in = 32'h1234_5678;
    rst = 1'b1;
    tick();

    pcen = 1;
    tick(10);
    pcen = 0;
    sb_push("instr_10", 32'd10);
    press();
    chk("sel_1", {29'h0, disp_sel}, 32'd1);
    sb_check();

    pcen = 1; jmp = 1; tick(3); jmp = 0;
    jr = 1; tick(2); jr = 0;
    branch_taken = 1; jmp = 1; tick(); jmp = 0;
    tick(3);
    idle_inputs();
    sb_push("instr_19", 32'd19);
    tick();
    sb_check();
    sb_push("jump_6", 32'd6);
    press();
    sb_check();
    sb_push("branch_3", 32'd3);
    press();
    chk("sel_3", {29'h0, disp_sel}, 32'd3);
    sb_check();

    for (int i = 0; i < 40; i++) begin
      btn_raw = i[0] ? 1'b0 : 1'b1;
      tick();
    end
    btn_raw = 0;
    tick(3);
    chk("bounce_no_adv", {29'h0, disp_sel}, 32'd3);

    btn_raw = 1;
    tick(D + 1);
    chk("hold_before_edge", {29'h0, disp_sel}, 32'd3);
    tick();
    chk("hold_at_edge", {29'h0, disp_sel}, 32'd4);
    tick(100 - (D + 2));
    chk("hold_one_adv", {29'h0, disp_sel}, 32'd4);
    btn_raw = 0;
    tick(3);
    sb_push("print_0", 32'd0);
    sb_check();

    sb_push("led_in", 32'h1234_5678);
    press();
    chk("wrap_sel_0", {29'h0, disp_sel}, 32'd0);
    sb_check();
    for (int i = 1; i <= 5; i++) press();
    chk("five_presses_0", {29'h0, disp_sel}, 32'd0);

    pcen = 1; syscall = 1; v0_is_34 = 1;
    tick(2);
    pcen = 0; v0_is_34 = 0;
    chk("pre_halt", {31'h0, halted}, 32'd0);
    tick();
    syscall = 0;
    chk("halted", {31'h0, halted}, 32'd1);
    pcen = 1; jmp = 1; tick(5);
    syscall = 1; v0_is_34 = 1; tick(2);
    idle_inputs();
    sb_push("halt_instr_21", 32'd21);
    press();
    sb_check();
    sb_push("halt_jump_6", 32'd6);
    press();
    sb_check();
    press();
    sb_push("halt_print_2", 32'd2);
    press();
    chk("halt_sel_4", {29'h0, disp_sel}, 32'd4);
    sb_check();

    // Partial debounce in HALT, then async reset between edges
    btn_raw = 1;
    tick(8);
    #2 rst = 1'b0;
    #1;
    chk("async_halted", {31'h0, halted}, 32'd0);
    chk("async_sel", {29'h0, disp_sel}, 32'd0);
    chk("async_data", disp_data, 32'd0);
    #1 rst = 1'b1;
    tick(D + 1);
    chk("deb_cleared", {29'h0, disp_sel}, 32'd0);
    tick();
    chk("deb_restart", {29'h0, disp_sel}, 32'd1);
    btn_raw = 0;
    tick(3);
    sb_push("instr_after_rst", 32'd0);
    sb_check();

    force dut.instr_cnt_q = 32'hFFFF_FFFE;
    pcen = 1;
    #2 release dut.instr_cnt_q;
    tick(3);
    pcen = 0;
    sb_push("instr_sat", 32'hFFFF_FFFF);
    tick();
    sb_check();

    force dut.disp_sel_q = 3'd5;
    #1 release dut.disp_sel_q;
    tick(2);
    chk("sel5_data", disp_data, 32'd0);
    press();
    chk("sel5_next_0", {29'h0, disp_sel}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_stat_monitor.md
Name: perf_stat_monitor

Overview:
- Run-statistics and display-source selector placed directly downstream of the single-cycle CPU core, between the core and the seven-segment display driver.
- Counts retired instructions, unconditional jumps, taken conditional branches and display-syscalls (syscall with $v0=34), and detects the halt syscall.
- Registers one of five 32-bit sources for the display driver; the source is chosen by a debounced push-button.

Parameters:
- DATA_BITS, 32, width of counters and display data.
- DEBOUNCE_CYCLES, 16, consecutive stable-high samples required to accept a button press (≥2).
- CNT_BITS, 5, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  CPU clock (the same divided clock that drives the PC register, regfile and memory).
- rst  in  1  asynchronous, active-low reset.
- pcen  in  1  PC enable from the core; 1 = the current instruction retires this edge.
- syscall  in  1  Syscall decode from the controller.
- v0_is_34  in  1  $v0 == 34 for the current instruction.
- jmp  in  1  Jmp decode (j/jal).
- jr  in  1  Jr decode.
- branch_taken  in  1  conditional-branch select (pcsel) from the branch unit.
- led_in  in  DATA_BITS  latched display value from the core's syscall-34 register.
- btn_raw  in  1  unsynchronised push-button, active-high.
- disp_data  out  DATA_BITS  registered data for the seven-segment driver.
- disp_sel  out  3  current source index (for the LEDs).
- halted  out  1  core has executed the halt syscall.

Behaviour:
- Reset (rst=0, async): all counters 0, disp_sel=0, disp_data=0, halted=0, FSM=RUN, synchroniser and debounce state 0.
- FSM: RUN -> HALT on the edge where syscall=1 and v0_is_34=0 (halt syscall; the core's pcen is 0 then). HALT is terminal; only reset exits it. halted=1 exactly while in HALT, registered, asserted the edge after detection.
- Counters are DATA_BITS wide, saturate at all-ones (no wrap), and update only in RUN:
  - instr_cnt +1 when pcen=1.
  - jump_cnt +1 when pcen=1 and (jmp|jr).
  - branch_cnt +1 when pcen=1 and branch_taken and !jmp and !jr.
  - print_cnt +1 when syscall=1 and v0_is_34=1.
  - The halt-syscall cycle is not counted in instr_cnt.
- In HALT all counters freeze. The button and display still operate.
- Button path:
  - Two-flop synchroniser.
  - Debounce counter resets to 0 whenever the synced value is 0. It increments while the value is 1, saturating at DEBOUNCE_CYCLES.
  - A one-cycle press pulse fires on the transition to DEBOUNCE_CYCLES. A held button produces exactly one pulse; a new pulse needs a release (≥1 low sample).
- disp_sel advances 0→1→2→3→4→0 on each press pulse.
- Source map: 0=led_in, 1=instr_cnt, 2=jump_cnt, 3=branch_cnt, 4=print_cnt.
- disp_data is registered every edge from the source chosen by the current disp_sel. Latency is 1 cycle from a counter/led_in change or a disp_sel change.
- Simultaneous events:
  - Press pulse and counter update in the same edge: both take effect; disp_data shows the old selection with the old value that edge and the new selection next edge.
  - Halt detection and a counter condition in the same edge: the counter still updates (RUN at that edge).
- Reset mid-operation clears everything immediately (async), including a partially debounced press.
- Values of disp_sel 5–7 are unreachable; if forced, disp_data=0 and the next press goes to 0.

Test Plan:
- Reset with rst=0, toggle all inputs -> all outputs 0. Release rst; drive 10 cycles pcen=1 -> instr_cnt=10; press to sel 1 -> disp_data=10.
- 3 cycles pcen=1,jmp=1; 2 cycles pcen=1,jr=1; 4 cycles branch_taken=1 (one with jmp=1) -> jump_cnt=6, branch_cnt=3.
- btn_raw bouncing 1/0 each cycle for 40 cycles -> no sel change. Held high 100 cycles -> exactly one advance, after 2+DEBOUNCE_CYCLES edges. Five clean presses -> sel returns to 0.
- syscall=1,v0_is_34=1 twice, then syscall=1,v0_is_34=0 -> print_cnt=2, halted=1 next edge. Further pcen=1 cycles leave instr_cnt unchanged. Display selection still works.
- Preload instr_cnt to 0xFFFFFFFE via force, 3 retiring cycles -> 0xFFFFFFFF held.
- Assert rst=0 asynchronously mid-debounce and in HALT -> immediate clear. halted=0 and disp_sel=0 without waiting for a clock edge.
